// File: rtl/cic_sched.sv
// Round-robin tick scheduler and shared time-constant manager for NCH parallel CIC decimators.
// Each sample occupies one 4-cycle slot (tick 2 high, 2 low); TC changes only between slots.
module cic_sched #(
  parameter int NCH    = 2,
  parameter int RATE   = 4,
  parameter int TC_MAX = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         req,
  output logic [NCH-1:0]         gnt,
  output logic [$clog2(NCH)-1:0] sel,
  output logic [NCH-1:0]         tick,
  input  logic [3:0]             tc_req,
  input  logic                   tc_load,
  output logic [3:0]             tc,
  output logic                   tc_busy,
  output logic                   out_valid,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic [NCH-1:0]         settled
);
  localparam int SW = $clog2(NCH);
  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;

  typedef enum logic [2:0] {IDLE, HI1, HI2, LO1, LO2} state_t;

  state_t        state;
  logic [SW-1:0] rr_ptr;
  logic [CW-1:0] cnt  [NCH];
  logic [7:0]    scnt [NCH];
  logic [3:0]    tc_pend;
  logic          dec;

  logic           found;
  logic [SW-1:0]  pick;
  logic [SW-1:0]  idx;
  logic [NCH-1:0] pick_oh;
  logic [3:0]     ld_val;
  logic [7:0]     tgt;

  always_comb begin
    found   = 1'b0;
    pick    = rr_ptr;
    idx     = '0;
    pick_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = SW'((int'(rr_ptr) + i) % NCH);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    pick_oh[pick] = 1'b1;
    ld_val = (tc_req > 4'(TC_MAX)) ? 4'(TC_MAX) : tc_req;
    tgt    = 8'((32'd1 << tc) + 32'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      sel       <= '0;
      tick      <= '0;
      tc        <= '0;
      tc_pend   <= '0;
      tc_busy   <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      settled   <= '0;
      dec       <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        cnt[c]  <= '0;
        scnt[c] <= '0;
      end
    end else begin
      gnt       <= '0;
      out_valid <= 1'b0;
      if (tc_load) begin
        tc_pend <= ld_val;
        tc_busy <= 1'b1;
      end
      case (state)
        // LO2 doubles as the slot boundary so back-to-back slots stay 4 cycles long
        IDLE, LO2: begin
          if (tc_busy || tc_load) begin
            tc      <= tc_load ? ld_val : tc_pend;
            tc_busy <= 1'b0;
            settled <= '0;
            for (int c = 0; c < NCH; c++) scnt[c] <= '0;
            state   <= IDLE;
          end else if (found) begin
            sel    <= pick;
            gnt    <= pick_oh;
            tick   <= pick_oh;
            rr_ptr <= (int'(pick) == NCH - 1) ? '0 : pick + 1'b1;
            state  <= HI1;
          end else begin
            state <= IDLE;
          end
        end
        HI1: begin
          dec      <= (cnt[sel] == '0);
          cnt[sel] <= (cnt[sel] == CW'(RATE - 1)) ? '0 : cnt[sel] + 1'b1;
          state    <= HI2;
        end
        HI2: begin
          tick  <= '0;
          state <= LO1;
          // History counts as refilled only once the saturated count is seen again
          if (dec) begin
            if (scnt[sel] < tgt) scnt[sel] <= scnt[sel] + 8'd1;
            settled[sel] <= settled[sel] | (scnt[sel] == tgt);
            out_valid    <= settled[sel] | (scnt[sel] == tgt);
            out_ch       <= sel;
          end
        end
        LO1:     state <= LO2;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_sched.sv
// Bench for cic_sched: randomized request streams checked against a slot-level reference model.
`timescale 1ns/1ps
module tb_cic_sched;
  localparam int NCH = 2, RATE = 4, TC_MAX = 7;
  localparam int SW = $clog2(NCH);

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] gnt, tick, settled;
  logic [SW-1:0]  sel, out_ch;
  logic [3:0]     tc_req = '0;
  logic           tc_load = 1'b0;
  logic [3:0]     tc;
  logic           tc_busy, out_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: rr priority, per-channel sample counts and decimations since last TC change
  int m_rr;
  int m_cnt [NCH];
  int m_dec [NCH];
  int m_tc;

  cic_sched #(.NCH(NCH), .RATE(RATE), .TC_MAX(TC_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel), .tick(tick),
    .tc_req(tc_req), .tc_load(tc_load), .tc(tc), .tc_busy(tc_busy),
    .out_valid(out_valid), .out_ch(out_ch), .settled(settled)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_rr = 0;
    m_tc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0;
      m_dec[c] = 0;
    end
  endfunction

  function automatic void model_apply(input int v);
    m_tc = v;
    for (int c = 0; c < NCH; c++) m_dec[c] = 0;
  endfunction

  function automatic int rr_pick(input logic [NCH-1:0] r);
    logic [NCH-1:0] t;
    for (int i = 0; i < NCH; i++) begin
      t = r >> ((m_rr + i) % NCH);
      if (t[0]) return (m_rr + i) % NCH;
    end
    return -1;
  endfunction

  // Returns whether this grant should produce a visible output
  function automatic bit model_grant(input int ch);
    bit d;
    d = (m_cnt[ch] == 0);
    m_cnt[ch] = (m_cnt[ch] + 1) % RATE;
    m_rr = (ch + 1) % NCH;
    if (d) m_dec[ch]++;
    return d && (m_dec[ch] > (1 << m_tc) + 1);
  endfunction

  function automatic logic [NCH-1:0] model_settled();
    logic [NCH-1:0] s;
    s = '0;
    for (int c = 0; c < NCH; c++)
      if (m_dec[c] > (1 << m_tc) + 1) s = s | (NCH'(1) << c);
    return s;
  endfunction

  task automatic wait_gnt(output int ch, output int lat);
    logic [NCH-1:0] t;
    ch  = -1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        lat = k;
        for (int c = 0; c < NCH; c++) begin
          t = gnt >> c;
          if (t[0]) ch = c;
        end
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt !== '0)       begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (sel !== '0)       begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++; if (tick !== '0)      begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (tc !== 4'd0)      begin errors++; $display("FAIL reset_tc: got %0d want 0", tc); end
    checks++; if (tc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tc_busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", out_valid); end
    checks++; if (out_ch !== '0)    begin errors++; $display("FAIL reset_och: got %0d want 0", out_ch); end
    checks++; if (settled !== '0)   begin errors++; $display("FAIL reset_settled: got %b want 0", settled); end
    @(negedge clk);
    @(negedge clk);
    req   = '1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Full per-slot checks; rnd re-draws req every slot, including idle gaps
  task automatic test_stream(input int n, input bit rnd);
    for (int s = 0; s < n; s++) begin
      int want, ch, lat;
      bit ov;
      logic [NCH-1:0] oh;
      want = rr_pick(req);
      wait_gnt(ch, lat);
      oh = NCH'(1) << want;
      checks++; if (lat != 1)     begin errors++; $display("FAIL slot_lat: got %0d want 1 (slot %0d)", lat, s); end
      checks++; if (ch != want)   begin errors++; $display("FAIL slot_ch: got %0d want %0d (slot %0d)", ch, want, s); end
      checks++; if (tick !== oh)  begin errors++; $display("FAIL slot_tick_hi1: got %b want %b", tick, oh); end
      checks++; if (sel !== SW'(want)) begin errors++; $display("FAIL slot_sel: got %0d want %0d", sel, want); end
      ov = model_grant(want);
      if (rnd) req = NCH'($urandom_range(0, (1 << NCH) - 1));
      @(negedge clk);
      checks++; if (tick !== oh)  begin errors++; $display("FAIL slot_tick_hi2: got %b want %b", tick, oh); end
      checks++; if (gnt !== '0)   begin errors++; $display("FAIL slot_gnt_width: got %b want 0", gnt); end
      @(negedge clk);
      checks++; if (tick !== '0)  begin errors++; $display("FAIL slot_tick_lo1: got %b want 0", tick); end
      checks++; if (out_valid !== ov) begin errors++; $display("FAIL slot_ov: got %b want %b (slot %0d)", out_valid, ov, s); end
      if (ov) begin
        checks++; if (out_ch !== SW'(want)) begin errors++; $display("FAIL slot_out_ch: got %0d want %0d", out_ch, want); end
      end
      checks++; if (settled !== model_settled()) begin errors++; $display("FAIL slot_settled: got %b want %b", settled, model_settled()); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL slot_ov_width: got %b want 0", out_valid); end
      if (rnd && req == '0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        req = NCH'($urandom_range(1, (1 << NCH) - 1));
      end
    end
  endtask

  task automatic test_tc_clamp();
    int want, ch, lat;
    want = rr_pick(req);
    wait_gnt(ch, lat);
    checks++; if (ch != want) begin errors++; $display("FAIL clamp_ch: got %0d want %0d", ch, want); end
    void'(model_grant(want));
    tc_load = 1'b1;
    tc_req  = 4'd9;
    @(negedge clk);
    tc_load = 1'b0;
    checks++; if (tc_busy !== 1'b1)  begin errors++; $display("FAIL clamp_busy: got %b want 1", tc_busy); end
    checks++; if (tc !== 4'(m_tc))   begin errors++; $display("FAIL clamp_tc_early: got %0d want %0d", tc, m_tc); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (tc_busy !== 1'b1)  begin errors++; $display("FAIL clamp_busy_lo2: got %b want 1", tc_busy); end
    @(negedge clk);
    model_apply(TC_MAX);
    checks++; if (tc !== 4'(TC_MAX)) begin errors++; $display("FAIL clamp_tc: got %0d want %0d", tc, TC_MAX); end
    checks++; if (tc_busy !== 1'b0)  begin errors++; $display("FAIL clamp_busy_clr: got %b want 0", tc_busy); end
    checks++; if (settled !== '0)    begin errors++; $display("FAIL clamp_settled: got %b want 0", settled); end
    checks++; if (gnt !== '0)        begin errors++; $display("FAIL clamp_gnt_delay: got %b want 0", gnt); end
    want = rr_pick(req);
    wait_gnt(ch, lat);
    checks++; if (lat != 1 || ch != want) begin errors++; $display("FAIL clamp_next: got ch %0d lat %0d want ch %0d lat 1", ch, lat, want); end
    void'(model_grant(want));
    repeat (3) @(negedge clk);
  endtask

  task automatic test_double_load();
    int want, ch, lat;
    want = rr_pick(req);
    wait_gnt(ch, lat);
    void'(model_grant(want));
    tc_load = 1'b1;
    tc_req  = 4'd3;
    @(negedge clk);
    tc_req  = 4'd5;
    @(negedge clk);
    tc_load = 1'b0;
    checks++; if (tc !== 4'(m_tc)) begin errors++; $display("FAIL dbl_tc_early: got %0d want %0d", tc, m_tc); end
    @(negedge clk);
    @(negedge clk);
    model_apply(5);
    checks++; if (tc !== 4'd5)     begin errors++; $display("FAIL dbl_tc: got %0d want 5", tc); end
    checks++; if (tc_busy !== 1'b0) begin errors++; $display("FAIL dbl_busy: got %b want 0", tc_busy); end
    want = rr_pick(req);
    wait_gnt(ch, lat);
    checks++; if (lat != 1 || ch != want) begin errors++; $display("FAIL dbl_next: got ch %0d lat %0d want ch %0d", ch, lat, want); end
    void'(model_grant(want));
    repeat (3) @(negedge clk);
    // Strobe in the boundary cycle itself: applied on that same edge
    tc_load = 1'b1;
    tc_req  = 4'd4;
    @(negedge clk);
    tc_load = 1'b0;
    model_apply(4);
    checks++; if (tc !== 4'd4)      begin errors++; $display("FAIL bnd_tc: got %0d want 4", tc); end
    checks++; if (tc_busy !== 1'b0) begin errors++; $display("FAIL bnd_busy: got %b want 0", tc_busy); end
    checks++; if (gnt !== '0)       begin errors++; $display("FAIL bnd_gnt_delay: got %b want 0", gnt); end
    want = rr_pick(req);
    wait_gnt(ch, lat);
    checks++; if (lat != 1 || ch != want) begin errors++; $display("FAIL bnd_next: got ch %0d lat %0d want ch %0d", ch, lat, want); end
    void'(model_grant(want));
    repeat (3) @(negedge clk);
  endtask

  task automatic test_glitch();
    int ch, lat, grants;
    req = NCH'(2);
    wait_gnt(ch, lat);
    checks++; if (ch != 1) begin errors++; $display("FAIL glitch_first: got %0d want 1", ch); end
    void'(model_grant(1));
    req = NCH'(3);
    @(negedge clk);
    req = NCH'(2);
    grants = 0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      checks++; if (gnt[0] !== 1'b0 || tick[0] !== 1'b0) begin errors++; $display("FAIL glitch_ch0: gnt %b tick %b want bit0 low", gnt, tick); end
      if (gnt[1]) begin grants++; void'(model_grant(1)); end
    end
    checks++; if (grants != 3) begin errors++; $display("FAIL glitch_grants: got %0d want 3", grants); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_slot();
    int ch, lat;
    req = '1;
    wait_gnt(ch, lat);
    void'(model_grant(ch));
    @(negedge clk);
    checks++; if (tick == '0) begin errors++; $display("FAIL rst_mid_pre: got tick %b want nonzero", tick); end
    rst_n = 1'b0;
    #1;
    checks++; if (tick !== '0) begin errors++; $display("FAIL rst_mid_tick: got %b want 0", tick); end
    checks++; if (gnt !== '0)  begin errors++; $display("FAIL rst_mid_gnt: got %b want 0", gnt); end
    checks++; if (tc !== 4'd0 || sel !== '0 || settled !== '0) begin errors++; $display("FAIL rst_mid_state: tc %0d sel %0d settled %b want 0", tc, sel, settled); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_settle();
    int ch, lat, first_ov, n_ov;
    bit ov;
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    tc_load = 1'b1;
    tc_req  = 4'd2;
    @(negedge clk);
    tc_load = 1'b0;
    model_apply(2);
    checks++; if (tc !== 4'd2 || tc_busy !== 1'b0) begin errors++; $display("FAIL settle_apply: tc %0d busy %b want 2/0", tc, tc_busy); end
    req = NCH'(2);
    first_ov = 0;
    n_ov = 0;
    for (int g = 1; g <= 28; g++) begin
      wait_gnt(ch, lat);
      checks++; if (ch != 1 || lat != 1) begin errors++; $display("FAIL settle_gnt: got ch %0d lat %0d want 1/1", ch, lat); end
      ov = model_grant(1);
      @(negedge clk);
      @(negedge clk);
      checks++; if (out_valid !== ov) begin errors++; $display("FAIL settle_ov: got %b want %b (grant %0d)", out_valid, ov, g); end
      if (out_valid) begin
        n_ov++;
        if (first_ov == 0) first_ov = g;
        checks++; if (out_ch !== SW'(1)) begin errors++; $display("FAIL settle_out_ch: got %0d want 1", out_ch); end
      end
      @(negedge clk);
    end
    checks++; if (first_ov != 21) begin errors++; $display("FAIL settle_first: got grant %0d want 21", first_ov); end
    checks++; if (n_ov != 2)      begin errors++; $display("FAIL settle_count: got %0d want 2", n_ov); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream(20, 1'b0);
    test_stream(40, 1'b1);
    req = '1;
    test_tc_clamp();
    test_double_load();
    test_glitch();
    test_reset_mid_slot();
    test_stream(20, 1'b0);
    test_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
